sum_uart_framer: RTL and testbench

//   Parametrised operand-latch / add-subtract / UART-report unit with a built-in 8N1 serializer.

---
 rtl/sum_uart_framer.sv | 145 ++++++++++++++
 tb/tb_sum_uart_framer.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/sum_uart_framer.sv
// rtl/sum_uart_framer.sv - operand latch, add/subtract and framed 8N1 UART report of the result
// Optional checksum byte: define SUM_UART_FRAMER_CHECKSUM_EN.
module sum_uart_framer #(
    parameter int          DATA_W       = 8,
    parameter int          CLKS_PER_BIT = 868,
    parameter logic [7:0]  HDR_BYTE     = 8'hA5
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              save_a_n,
    input  logic              save_b_n,
    input  logic [DATA_W-1:0] data_input,
    input  logic              op_sub,
    input  logic              tx_start,
    output logic [DATA_W:0]   result,
    output logic              uart_txd,
    output logic              uart_busy,
    output logic              done
);
    localparam int NBYTES = (DATA_W + 8) / 8;
`ifdef SUM_UART_FRAMER_CHECKSUM_EN
    localparam int NFRAME = NBYTES + 2;
`else
    localparam int NFRAME = NBYTES + 1;
`endif
    localparam int FRAME_W = NFRAME * 8;
    localparam int CNT_W   = $clog2(CLKS_PER_BIT);
    localparam int IDX_W   = $clog2(NFRAME);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] CNT_DONE = CNT_W'(CLKS_PER_BIT - 2);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NFRAME - 1);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t               state;
    logic [DATA_W-1:0]    a;
    logic [DATA_W-1:0]    b;
    logic [NBYTES*8-1:0]  res_pad;
    logic [FRAME_W-1:0]   frame_load;
    logic [FRAME_W-1:0]   frame_sr;
    logic [CNT_W-1:0]     baud_cnt;
    logic [2:0]           bit_idx;
    logic [IDX_W-1:0]     byte_idx;

    assign res_pad = (NBYTES * 8)'(result);

`ifdef SUM_UART_FRAMER_CHECKSUM_EN
    logic [7:0] checksum;

    always_comb begin
        checksum = HDR_BYTE;
        for (int i = 0; i < NBYTES; i++) begin
            checksum = checksum ^ res_pad[i*8 +: 8];
        end
    end

    assign frame_load = {checksum, res_pad, HDR_BYTE};
`else
    assign frame_load = {res_pad, HDR_BYTE};
`endif

    // The extra MSB of the subtraction is the borrow, since both operands are zero-extended.
    always_ff @(posedge clk) begin
        if (reset) begin
            a      <= '0;
            b      <= '0;
            result <= '0;
        end else begin
            if (!save_a_n) a <= data_input;
            if (!save_b_n) b <= data_input;
            result <= op_sub ? ({1'b0, a} - {1'b0, b}) : ({1'b0, a} + {1'b0, b});
        end
    end

    // frame_sr holds the whole frame, LSB of the current byte at bit 0, shifted once per data bit.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            uart_txd  <= 1'b1;
            uart_busy <= 1'b0;
            done      <= 1'b0;
            baud_cnt  <= '0;
            bit_idx   <= '0;
            byte_idx  <= '0;
            frame_sr  <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (tx_start) begin
                        state     <= START;
                        frame_sr  <= frame_load;
                        uart_txd  <= 1'b0;
                        uart_busy <= 1'b1;
                        baud_cnt  <= '0;
                        byte_idx  <= '0;
                    end
                end
                START: begin
                    if (baud_cnt == CNT_LAST) begin
                        state    <= DATA;
                        baud_cnt <= '0;
                        bit_idx  <= '0;
                        uart_txd <= frame_sr[0];
                        frame_sr <= frame_sr >> 1;
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end
                DATA: begin
                    if (baud_cnt == CNT_LAST) begin
                        baud_cnt <= '0;
                        if (bit_idx == 3'd7) begin
                            state    <= STOP;
                            uart_txd <= 1'b1;
                        end else begin
                            bit_idx  <= bit_idx + 1'b1;
                            uart_txd <= frame_sr[0];
                            frame_sr <= frame_sr >> 1;
                        end
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end
                STOP: begin
                    if (baud_cnt == CNT_LAST) begin
                        baud_cnt <= '0;
                        if (byte_idx == IDX_LAST) begin
                            state     <= IDLE;
                            uart_busy <= 1'b0;
                        end else begin
                            state    <= START;
                            byte_idx <= byte_idx + 1'b1;
                            uart_txd <= 1'b0;
                        end
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                        if (baud_cnt == CNT_DONE && byte_idx == IDX_LAST) done <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_sum_uart_framer.sv
// tb/tb_sum_uart_framer.sv - directed and random checks of sum_uart_framer against a cycle model
module tb_sum_uart_framer;
    localparam int DATA_W = 8;
    localparam int CPB    = 4;
    localparam int NB     = 2;
`ifdef SUM_UART_FRAMER_CHECKSUM_EN
    localparam int NFR = NB + 2;
`else
    localparam int NFR = NB + 1;
`endif
    localparam int FLEN = 10 * CPB * NFR;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              save_a_n = 1'b1;
    logic              save_b_n = 1'b1;
    logic              op_sub = 1'b0;
    logic              tx_start = 1'b0;
    logic [DATA_W-1:0] data_input = '0;
    logic [DATA_W:0]   result;
    logic              uart_txd;
    logic              uart_busy;
    logic              done;

    int total = 0;
    int bad = 0;
    int done_cnt = 0;
    bit checking = 0;

    always #5 clk = ~clk;

    sum_uart_framer #(.DATA_W(DATA_W), .CLKS_PER_BIT(CPB), .HDR_BYTE(8'hA5)) dut (
        .clk(clk), .reset(reset), .save_a_n(save_a_n), .save_b_n(save_b_n),
        .data_input(data_input), .op_sub(op_sub), .tx_start(tx_start),
        .result(result), .uart_txd(uart_txd), .uart_busy(uart_busy), .done(done)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Behavioural model: operands, result, and frame timeline as elapsed cycles since busy rise.
    int a_m = 0, b_m = 0, res_m = 0, t_m = 0;
    bit busy_m = 0;
    int eb[4];

    always @(posedge clk) begin
        if (reset) begin
            a_m = 0; b_m = 0; res_m = 0; busy_m = 0; t_m = 0;
        end else begin
            if (!busy_m && tx_start) begin
                eb[0] = 'hA5;
                eb[1] = res_m % 256;
                eb[2] = res_m / 256;
                eb[3] = eb[0] ^ eb[1] ^ eb[2];
                busy_m = 1;
                t_m = 0;
            end else if (busy_m) begin
                if (t_m == FLEN - 1) busy_m = 0;
                else t_m++;
            end
            res_m = op_sub ? ((a_m - b_m) + 512) % 512 : a_m + b_m;
            if (!save_a_n) a_m = data_input;
            if (!save_b_n) b_m = data_input;
        end
    end

    function automatic logic exp_txd();
        int pos, k, bi;
        if (!busy_m) return 1'b1;
        pos = t_m / CPB;
        k   = pos / 10;
        bi  = pos % 10;
        if (bi == 0) return 1'b0;
        if (bi == 9) return 1'b1;
        return eb[k][bi-1];
    endfunction

    always @(negedge clk) begin
        if (checking) begin
            chk("cyc_result", result, res_m);
            chk("cyc_busy", uart_busy, busy_m);
            chk("cyc_done", done, busy_m && t_m == FLEN - 1);
            chk("cyc_txd", uart_txd, exp_txd());
            if (done === 1'b1) done_cnt++;
        end
    end

    // Independent UART receiver sampling mid-bit.
    int rx_q[$];
    bit rx_on = 0;
    int rx_c = 0;
    logic [7:0] rx_b = '0;

    always @(posedge clk) begin
        if (reset) begin
            rx_on = 0;
        end else if (!rx_on) begin
            if (uart_txd === 1'b0) begin
                rx_on = 1;
                rx_c = 1;
            end
        end else begin
            if (rx_c >= CPB + CPB / 2 && rx_c < CPB * 9 && (rx_c - CPB / 2) % CPB == 0)
                rx_b[(rx_c - CPB - CPB / 2) / CPB] = uart_txd;
            if (rx_c == CPB * 9 + CPB / 2) begin
                rx_q.push_back(int'(rx_b));
                rx_on = 0;
            end
            rx_c++;
        end
    end

    task automatic load(input logic [7:0] a, input logic [7:0] b, input logic s);
        data_input = a; save_a_n = 0; tick(); save_a_n = 1;
        data_input = b; save_b_n = 0; tick(); save_b_n = 1;
        op_sub = s; tick(); tick();
    endtask

    task automatic send_frame(input string tag, input int poke, input int e0, input int e1,
                              input int e2, input int e3);
        int n;
        bit seen;
        int e[4];
        e[0] = e0; e[1] = e1; e[2] = e2; e[3] = e3;
        rx_q.delete();
        done_cnt = 0;
        n = 0;
        seen = 0;
        tx_start = 1; tick(); tx_start = 0;
        for (int i = 0; i < 2000 && !seen; i++) begin
            if (uart_busy) n++;
            if (done) begin
                seen = 1;
            end else begin
                if (i == poke) begin
                    tx_start = 1; save_a_n = 0; data_input = 8'hFF;
                end else begin
                    tx_start = 0; save_a_n = 1;
                end
                tick();
            end
        end
        tx_start = 0; save_a_n = 1;
        chk({tag, "_done_seen"}, seen, 1);
        chk({tag, "_busy_len"}, n, FLEN);
        tick();
        chk({tag, "_busy_fall"}, uart_busy, 0);
        repeat (50) tick();
        chk({tag, "_one_done"}, done_cnt, 1);
        chk({tag, "_nbytes"}, rx_q.size(), NFR);
        for (int k = 0; k < rx_q.size() && k < NFR; k++)
            chk($sformatf("%s_byte%0d", tag, k), rx_q[k], e[k]);
    endtask

    initial begin
        repeat (2) tick();
        checking = 1;
        chk("rst_result", result, 0);
        chk("rst_txd", uart_txd, 1);
        chk("rst_busy", uart_busy, 0);
        chk("rst_done", done, 0);
        reset = 0;
        tick();

        load(8'h12, 8'h34, 0);
        chk("add_result", result, 'h046);
        send_frame("add", -1, 'hA5, 'h46, 'h00, 'hE3);
        chk("model_byte1", eb[1], 'h46);

        load(8'hC8, 8'h64, 0);
        chk("carry_result", result, 'h12C);
        send_frame("carry", -1, 'hA5, 'h2C, 'h01, 'h88);
        chk("model_chk", eb[3], 'h88);

        load(8'h05, 8'h07, 1);
        chk("sub_result", result, 'h1FE);
        send_frame("sub", -1, 'hA5, 'hFE, 'h01, 'h5A);

        load(8'hC8, 8'h64, 0);
        send_frame("snap", 50, 'hA5, 'h2C, 'h01, 'h88);
        chk("snap_newres", result, 'h163);

        data_input = 8'h21; save_a_n = 0; save_b_n = 0; tick();
        save_a_n = 1; save_b_n = 1; op_sub = 0; tick(); tick();
        chk("both_result", result, 'h042);
        done_cnt = 0;
        tx_start = 1; tick(); tx_start = 0;
        repeat (29) tick();
        reset = 1; tick(); reset = 0;
        chk("midrst_txd", uart_txd, 1);
        chk("midrst_busy", uart_busy, 0);
        chk("midrst_result", result, 0);
        chk("midrst_done", done, 0);
        repeat (FLEN + 20) tick();
        chk("midrst_no_done", done_cnt, 0);

        for (int i = 0; i < 4000; i++) begin
            save_a_n   = ($urandom % 4) != 0;
            save_b_n   = ($urandom % 4) != 0;
            data_input = DATA_W'($urandom);
            if ($urandom % 16 == 0) op_sub = 1'($urandom);
            tx_start   = ($urandom % 40) == 0;
            reset      = ($urandom % 1500) == 0;
            tick();
        end
        reset = 0; tx_start = 0; save_a_n = 1; save_b_n = 1;
        repeat (FLEN + 10) tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
